// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encoding and mode constants for the interval timer
package timer_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/tc_counter.sv
// tc_counter: WIDTH-bit up-counter with enable and synchronous clear
// ports: clk, rst (async active-low), en (increment), clr (sync clear, wins over en), q (count)
module tc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= q + 1'b1;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable one-shot/periodic interval timer around tc_counter
// ports: clk, rst (async active-low); start/stop/clr control strobes (clr > stop > start);
//        mode/limit sampled on launch; count, busy (RUN or HOLD), done (terminal pulse),
//        periods (saturating number of terminal counts since launch)
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic              mode,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PWIDTH-1:0] periods
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic mode_q, term, launch, cnt_en, cnt_clr;
  assign term   = state_q == RUN && count == limit_q;
  assign launch = !clr && state_q == IDLE && start && limit != '0;
  // the terminal event still happens on an edge that also carries stop
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_clr = clr || launch || (term && mode_q == MODE_PERIODIC);
    if (clr) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = launch ? RUN : IDLE;
        RUN: begin
          state_d = (term && mode_q == MODE_ONESHOT) ? IDLE : stop ? HOLD : RUN;
          cnt_en  = !term && !stop;
        end
        HOLD: state_d = (start && !stop) ? RUN : HOLD;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      periods <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= state_d != IDLE;
      done    <= term && !clr;
      if (launch) begin
        limit_q <= limit;
        mode_q  <= mode;
        periods <= '0;
      end else if (term && !clr && periods != '1) periods <= periods + 1'b1;
    end
  tc_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en (cnt_en),
    .clr(cnt_clr),
    .q  (count)
  );
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench for timer_ctrl, one task per scenario
module tb_timer_ctrl;
  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       d;
    logic [7:0] p;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, clr = 1'b0, mode = 1'b0;
  logic [7:0] limit = 8'd0, count, periods;
  logic busy, done;
  int total = 0, bad = 0;
  obs_t q[$];
  timer_ctrl #(.WIDTH(8), .PWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .mode(mode),
    .limit(limit), .count(count), .busy(busy), .done(done), .periods(periods)
  );
  always #5 clk = ~clk;
  function automatic obs_t mk(int c, int b, int d, int p);
    mk.c = 8'(c);
    mk.b = 1'(b);
    mk.d = 1'(d);
    mk.p = 8'(p);
  endfunction
  function automatic obs_t now();
    now.c = count;
    now.b = busy;
    now.d = done;
    now.p = periods;
  endfunction
  function automatic string fmt(obs_t o);
    return $sformatf("count=%0d busy=%0b done=%0b periods=%0d", o.c, o.b, o.d, o.p);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    obs_t e, o;
    rst = 1'b0;
    tick();
    e = mk(0, 0, 0, 0); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_init: got %s want %s", fmt(o), fmt(e)); end
    rst = 1'b1;
    limit = 8'd10; mode = 1'b0; start = 1'b1;
    for (int i = 0; i <= 4; i++) q.push_back(mk(i, 1, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_run[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    #2 rst = 1'b0;
    #1;
    e = mk(0, 0, 0, 0); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_async: got %s want %s", fmt(o), fmt(e)); end
    tick();
    o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_held: got %s want %s", fmt(o), fmt(e)); end
    rst = 1'b1;
  endtask
  task automatic test_oneshot();
    obs_t e, o;
    limit = 8'd3; mode = 1'b0; start = 1'b1;
    for (int i = 0; i <= 3; i++) q.push_back(mk(i, 1, 0, 0));
    q.push_back(mk(3, 0, 1, 1));
    q.push_back(mk(3, 0, 0, 1));
    q.push_back(mk(3, 0, 0, 1));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL oneshot[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_periodic();
    obs_t e, o;
    limit = 8'd2; mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 10; i++) q.push_back(mk(i % 3, 1, int'(i > 0 && i % 3 == 0), i / 3));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL periodic[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    clr = 1'b1;
    tick(); clr = 1'b0;
    e = mk(0, 0, 0, 3); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL periodic_clr: got %s want %s", fmt(o), fmt(e)); end
  endtask
  task automatic test_hold();
    obs_t e, o;
    limit = 8'd5; mode = 1'b0; start = 1'b1;
    for (int i = 0; i <= 2; i++) q.push_back(mk(i, 1, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL hold_run[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    stop = 1'b1;
    for (int i = 0; i < 5; i++) q.push_back(mk(2, 1, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); stop = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL hold_frozen[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    start = 1'b1;
    for (int i = 2; i <= 5; i++) q.push_back(mk(i, 1, 0, 0));
    q.push_back(mk(5, 0, 1, 1));
    q.push_back(mk(5, 0, 0, 1));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL hold_resume[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask
  task automatic test_edges();
    obs_t e, o;
    limit = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    e = mk(5, 0, 0, 1); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL limit_zero: got %s want %s", fmt(o), fmt(e)); end
    limit = 8'd4; mode = 1'b1; start = 1'b1;
    q.push_back(mk(0, 1, 0, 0));
    q.push_back(mk(1, 1, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL prio_run[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    clr = 1'b1; stop = 1'b1; start = 1'b1;
    tick(); clr = 1'b0; stop = 1'b0; start = 1'b0;
    e = mk(0, 0, 0, 0); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL prio_clr: got %s want %s", fmt(o), fmt(e)); end
    limit = 8'd2; mode = 1'b1; start = 1'b1;
    for (int i = 0; i <= 2; i++) q.push_back(mk(i, 1, 0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL stopterm_run[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    stop = 1'b1;
    q.push_back(mk(0, 1, 1, 1));
    q.push_back(mk(0, 1, 0, 1));
    q.push_back(mk(0, 1, 0, 1));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); stop = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL stopterm_hold[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    start = 1'b1;
    q.push_back(mk(0, 1, 0, 1));
    q.push_back(mk(1, 1, 0, 1));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL stopterm_resume[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    clr = 1'b1;
    tick(); clr = 1'b0;
    e = mk(0, 0, 0, 1); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL stopterm_clr: got %s want %s", fmt(o), fmt(e)); end
  endtask
  task automatic test_saturation();
    obs_t e, o;
    limit = 8'd1; mode = 1'b1; start = 1'b1;
    for (int i = 0; i < 600; i++)
      q.push_back(mk(i % 2, 1, int'(i > 0 && i % 2 == 0), (i / 2 > 255) ? 255 : i / 2));
    for (int i = 0; q.size() > 0; i++) begin
      tick(); start = 1'b0;
      e = q.pop_front(); o = now(); total++;
      if (o !== e) begin bad++; $display("FAIL saturate[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    clr = 1'b1;
    tick(); clr = 1'b0;
    e = mk(0, 0, 0, 255); o = now(); total++;
    if (o !== e) begin bad++; $display("FAIL saturate_clr: got %s want %s", fmt(o), fmt(e)); end
  endtask
  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_hold();
    test_edges();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
